// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game session controller: state encoding,
// field widths, scoring constants and saturation limits.
package rhythm_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SONG_W   = 2;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned CD_W     = 25;
  localparam int unsigned SCORE_W  = 16;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned COMBO_W  = 8;
  localparam int unsigned PTS_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_RESULT    = 3'd4
  } state_e;

  localparam logic [PTS_W-1:0]    PTS_PERFECT = 3'd3;
  localparam logic [PTS_W-1:0]    PTS_GOOD    = 3'd1;
  localparam logic [PTS_W-1:0]    PTS_BONUS   = 3'd1;

  localparam logic [SCORE_W-1:0]  SCORE_MAX   = 16'hFFFF;
  localparam logic [CNT_W-1:0]    CNT_MAX     = 10'd1023;
  localparam logic [COMBO_W-1:0]  COMBO_MAX   = 8'd255;
  localparam logic [OFFSET_W-1:0] OFFSET_MAX  = 3'd6;

  // Points earned by one good press.
  function automatic logic [PTS_W-1:0] hit_points(input logic perfect, input logic bonus);
    logic [PTS_W-1:0] pts;
    pts = perfect ? PTS_PERFECT : PTS_GOOD;
    if (bonus) pts = pts + PTS_BONUS;
    return pts;
  endfunction

endpackage

// File: rtl/rhythm_game_ctrl_note_judge.sv
// Combinational press classifier for the judge row.
// Inputs : btn_red/btn_blue press pulses, note_R_judge/note_B_judge note
//          presence, offset and its one-cycle-delayed copy, hit_flag.
// Outputs: good (correct single-colour press), bad (wrong colour or both
//          buttons while a note is present), perfect (offset in window),
//          boundary (slot wrap from OFFSET_MAX to 0).
import rhythm_pkg::*;

module note_judge #(
  parameter int unsigned PERF_LO = 3,
  parameter int unsigned PERF_HI = 5
) (
  input  logic                btn_red,
  input  logic                btn_blue,
  input  logic                note_R_judge,
  input  logic                note_B_judge,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [OFFSET_W-1:0] offset_d,
  input  logic                hit_flag,
  output logic                good,
  output logic                bad,
  output logic                perfect,
  output logic                boundary
);

  logic solo_red, solo_blue, any_note;

  assign solo_red  = btn_red & ~btn_blue;
  assign solo_blue = btn_blue & ~btn_red;
  assign any_note  = note_R_judge | note_B_judge;

  // Once a slot's note is consumed (hit or missed) further presses are ignored.
  assign good = ~hit_flag & ((solo_red & note_R_judge) | (solo_blue & note_B_judge));
  assign bad  = ~hit_flag & any_note &
                ((btn_red & btn_blue) | (solo_red & ~note_R_judge) | (solo_blue & ~note_B_judge));

  assign perfect  = (offset >= OFFSET_W'(PERF_LO)) && (offset <= OFFSET_W'(PERF_HI));
  assign boundary = (offset_d == OFFSET_MAX) && (offset == '0);

endmodule

// File: rtl/rhythm_game_ctrl.sv
// Session controller for the LED-matrix rhythm game: song select, countdown,
// play and result phases; judges presses and keeps score/hit/miss/combo stats.
// Inputs : clk, rst (async, active-high), btn_red/btn_blue/btn_start pulses,
//          song_sw, note_R_judge/note_B_judge, offset, finish.
// Outputs: song, delete, yellow_button, state, countdown, score, hit_cnt,
//          miss_cnt, combo, max_combo (all registered).
import rhythm_pkg::*;

module rhythm_game_ctrl #(
  parameter int unsigned COUNTDOWN_CYC = 30_000_000,
  parameter int unsigned PERF_LO       = 3,
  parameter int unsigned PERF_HI       = 5,
  parameter int unsigned COMBO_BONUS   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_red,
  input  logic                btn_blue,
  input  logic                btn_start,
  input  logic [SONG_W-1:0]   song_sw,
  input  logic                note_R_judge,
  input  logic                note_B_judge,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                finish,
  output logic [SONG_W-1:0]   song,
  output logic                delete,
  output logic                yellow_button,
  output logic [STATE_W-1:0]  state,
  output logic [1:0]          countdown,
  output logic [SCORE_W-1:0]  score,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic [COMBO_W-1:0]  combo,
  output logic [COMBO_W-1:0]  max_combo
);

  // Countdown thirds resolved at elaboration so no runtime divider is needed.
  localparam logic [CD_W-1:0]    CD_LAST  = CD_W'(COUNTDOWN_CYC - 1);
  localparam logic [CD_W-1:0]    CD_T1    = CD_W'(COUNTDOWN_CYC / 3);
  localparam logic [CD_W-1:0]    CD_T2    = CD_W'((2 * COUNTDOWN_CYC) / 3);
  localparam logic [COMBO_W-1:0] BONUS_AT = COMBO_W'(COMBO_BONUS);

  state_e              state_q, state_d;
  logic [CD_W-1:0]     cnt_q, cnt_d;
  logic [SONG_W-1:0]   song_lat_q, song_lat_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [1:0]          countdown_q, countdown_d;
  logic                delete_q, delete_d;
  logic                yellow_q, yellow_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic [COMBO_W-1:0]  combo_q, combo_d;
  logic [COMBO_W-1:0]  max_combo_q, max_combo_d;
  logic                hit_flag_q, hit_flag_d;
  logic                note_seen_q, note_seen_d;
  logic [OFFSET_W-1:0] offset_d_q;

  logic                good_c, bad_c, perfect_c, boundary_c;
  logic [COMBO_W-1:0]  combo_inc;
  logic [SCORE_W:0]    score_sum;

  note_judge #(.PERF_LO(PERF_LO), .PERF_HI(PERF_HI)) u_judge (
    .btn_red      (btn_red),
    .btn_blue     (btn_blue),
    .note_R_judge (note_R_judge),
    .note_B_judge (note_B_judge),
    .offset       (offset),
    .offset_d     (offset_d_q),
    .hit_flag     (hit_flag_q),
    .good         (good_c),
    .bad          (bad_c),
    .perfect      (perfect_c),
    .boundary     (boundary_c)
  );

  // Next-state, judging and statistics.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    song_lat_d  = song_lat_q;
    delete_d    = 1'b0;
    yellow_d    = 1'b0;
    score_d     = score_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    hit_flag_d  = 1'b0;
    note_seen_d = 1'b0;
    combo_inc   = (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
    score_sum   = {1'b0, score_q} +
                  (SCORE_W+1)'(hit_points(perfect_c, combo_q >= BONUS_AT));

    case (state_q)
      ST_IDLE: begin
        if (song_sw != '0) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (song_sw == '0) begin
          state_d = ST_IDLE;
        end else if (btn_start) begin
          state_d     = ST_COUNTDOWN;
          song_lat_d  = song_sw;
          cnt_d       = '0;
          score_d     = '0;
          hit_cnt_d   = '0;
          miss_cnt_d  = '0;
          combo_d     = '0;
          max_combo_d = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (cnt_q == CD_LAST) begin
          cnt_d   = '0;
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q + CD_W'(1);
        end
      end
      ST_PLAY: begin
        if (finish) state_d = ST_RESULT;
        hit_flag_d  = hit_flag_q | good_c | bad_c;
        note_seen_d = note_seen_q | note_R_judge | note_B_judge;
        if (good_c) begin
          delete_d    = 1'b1;
          hit_cnt_d   = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
          combo_d     = combo_inc;
          max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
          score_d     = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
        end
        if (bad_c) begin
          miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
          combo_d    = '0;
        end
        // Slot wrap: an unjudged note in the closing slot is a miss. A press
        // in this same cycle has already set hit_flag_d and suppresses it.
        if (boundary_c) begin
          if (note_seen_q && !hit_flag_d) begin
            miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
            combo_d    = '0;
          end
          hit_flag_d  = 1'b0;
          note_seen_d = 1'b0;
        end
      end
      ST_RESULT: begin
        if (btn_start) begin
          state_d  = ST_IDLE;
          yellow_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs track the next state so they line up with it.
    song_d      = (state_d == ST_PLAY) ? song_lat_d : '0;
    countdown_d = '0;
    if (state_d == ST_COUNTDOWN) begin
      if (cnt_d < CD_T1)      countdown_d = 2'd3;
      else if (cnt_d < CD_T2) countdown_d = 2'd2;
      else                    countdown_d = 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      song_lat_q  <= '0;
      song_q      <= '0;
      countdown_q <= '0;
      delete_q    <= 1'b0;
      yellow_q    <= 1'b0;
      score_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      hit_flag_q  <= 1'b0;
      note_seen_q <= 1'b0;
      offset_d_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      song_lat_q  <= song_lat_d;
      song_q      <= song_d;
      countdown_q <= countdown_d;
      delete_q    <= delete_d;
      yellow_q    <= yellow_d;
      score_q     <= score_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      hit_flag_q  <= hit_flag_d;
      note_seen_q <= note_seen_d;
      offset_d_q  <= offset;
    end
  end

  assign state         = state_q;
  assign song          = song_q;
  assign countdown     = countdown_q;
  assign delete        = delete_q;
  assign yellow_button = yellow_q;
  assign score         = score_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign combo         = combo_q;
  assign max_combo     = max_combo_q;

endmodule

// File: tb/tb_rhythm_game_ctrl.sv
// Self-checking bench for rhythm_game_ctrl: directed table, hand sequences for
// multi-cycle corners, and random stimulus against a behavioural model.
module tb_rhythm_game_ctrl;

  localparam int CD = 9;

  logic       clk, rst;
  logic       btn_red, btn_blue, btn_start, note_r, note_b, finish;
  logic [1:0] song_sw;
  logic [2:0] offset;
  logic [1:0] t_song, t_countdown;
  logic       t_delete, t_yellow;
  logic [2:0] t_state;
  logic [15:0] t_score;
  logic [9:0] t_hit, t_miss;
  logic [7:0] t_combo, t_max;

  int n_checks = 0;
  int n_pass   = 0;

  rhythm_game_ctrl #(.COUNTDOWN_CYC(CD)) dut (
    .clk(clk), .rst(rst), .btn_red(btn_red), .btn_blue(btn_blue),
    .btn_start(btn_start), .song_sw(song_sw), .note_R_judge(note_r),
    .note_B_judge(note_b), .offset(offset), .finish(finish),
    .song(t_song), .delete(t_delete), .yellow_button(t_yellow),
    .state(t_state), .countdown(t_countdown), .score(t_score),
    .hit_cnt(t_hit), .miss_cnt(t_miss), .combo(t_combo), .max_combo(t_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  int m_state, m_cnt, m_lat, m_score, m_hit, m_miss, m_combo, m_max, m_offd;
  bit m_hitflag, m_seen;
  int e_song, e_cd;
  bit e_delete, e_yellow;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_lat = 0; m_score = 0; m_hit = 0; m_miss = 0;
    m_combo = 0; m_max = 0; m_offd = 0; m_hitflag = 0; m_seen = 0;
    e_song = 0; e_cd = 0; e_delete = 0; e_yellow = 0;
  endtask

  task automatic model_tick();
    int ns, pts;
    bit any, bnd, good, bad, pressed;
    ns = m_state; e_delete = 0; e_yellow = 0;
    any = note_r || note_b;
    pressed = btn_red || btn_blue;
    bnd = (m_offd == 6) && (offset == 0);
    if (m_state != 3) begin m_hitflag = 0; m_seen = 0; end
    case (m_state)
      0: if (song_sw != 0) ns = 1;
      1: if (song_sw == 0) ns = 0;
         else if (btn_start) begin
           ns = 2; m_lat = int'(song_sw); m_cnt = 0;
           m_score = 0; m_hit = 0; m_miss = 0; m_combo = 0; m_max = 0;
         end
      2: if (m_cnt == CD - 1) begin ns = 3; m_cnt = 0; end else m_cnt++;
      3: begin
        if (finish) ns = 4;
        good = !m_hitflag && ((btn_red && !btn_blue && note_r) || (btn_blue && !btn_red && note_b));
        bad  = !m_hitflag && any && pressed && !good;
        if (good) begin
          pts = (offset >= 3 && offset <= 5) ? 3 : 1;
          if (m_combo >= 10) pts++;
          m_score = imin(m_score + pts, 65535);
          m_hit   = imin(m_hit + 1, 1023);
          m_combo = imin(m_combo + 1, 255);
          if (m_combo > m_max) m_max = m_combo;
          e_delete = 1;
        end
        if (bad) begin m_miss = imin(m_miss + 1, 1023); m_combo = 0; end
        if (good || bad) m_hitflag = 1;
        if (bnd) begin
          if (m_seen && !m_hitflag) begin m_miss = imin(m_miss + 1, 1023); m_combo = 0; end
          m_hitflag = 0; m_seen = 0;
        end else if (any) m_seen = 1;
      end
      4: if (btn_start) begin ns = 0; e_yellow = 1; end
      default: ns = 0;
    endcase
    m_state = ns;
    m_offd  = int'(offset);
    e_song  = (m_state == 3) ? m_lat : 0;
    if (m_state != 2)            e_cd = 0;
    else if (m_cnt < CD / 3)     e_cd = 3;
    else if (m_cnt < 2 * CD / 3) e_cd = 2;
    else                         e_cd = 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] dut_vec();
    return {3'd0, t_state, t_song, t_countdown, t_delete, t_yellow,
            t_score, t_hit, t_miss, t_combo, t_max};
  endfunction

  function automatic logic [63:0] model_vec();
    return {3'd0, 3'(m_state), 2'(e_song), 2'(e_cd), e_delete, e_yellow,
            16'(m_score), 10'(m_hit), 10'(m_miss), 8'(m_combo), 8'(m_max)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic clear_pulses();
    btn_red = 0; btn_blue = 0; btn_start = 0; note_r = 0; note_b = 0; finish = 0;
  endtask

  task automatic go_play(input logic [1:0] sw);
    song_sw = sw; offset = 0; clear_pulses();
    step();
    btn_start = 1; step(); btn_start = 0;
    repeat (CD) step();
  endtask

  task automatic perfect_hit();
    offset = 4; note_r = 1; btn_red = 1; step();
    note_r = 0; btn_red = 0;
    offset = 6; step();
    offset = 0; step();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic red, blue, nr, nb;
    logic [2:0] off;
    logic del;
    logic [15:0] score;
    logic [9:0] hit, miss;
    logic [7:0] combo, maxc;
  } vec_t;

  function automatic vec_t mkv(input int r, b, nr, nb, off, del, sc, h, m, c, mx);
    vec_t v;
    v.red = 1'(r); v.blue = 1'(b); v.nr = 1'(nr); v.nb = 1'(nb); v.off = 3'(off);
    v.del = 1'(del); v.score = 16'(sc); v.hit = 10'(h); v.miss = 10'(m);
    v.combo = 8'(c); v.maxc = 8'(mx);
    return v;
  endfunction

  vec_t tbl[18];
  int   cd_exp[9];

  initial begin
    //             r b nr nb off  del sc h m c mx
    tbl[0]  = mkv(1,0,1,0,4, 1,3,1,0,1,1);   // perfect hit
    tbl[1]  = mkv(0,0,1,0,5, 0,3,1,0,1,1);
    tbl[2]  = mkv(0,0,0,0,6, 0,3,1,0,1,1);
    tbl[3]  = mkv(0,0,0,0,0, 0,3,1,0,1,1);   // boundary, already hit
    tbl[4]  = mkv(1,0,1,0,1, 1,4,2,0,2,2);   // good (not perfect) hit
    tbl[5]  = mkv(0,0,0,0,6, 0,4,2,0,2,2);
    tbl[6]  = mkv(0,0,0,0,0, 0,4,2,0,2,2);
    tbl[7]  = mkv(0,0,0,1,2, 0,4,2,0,2,2);   // blue note, no press
    tbl[8]  = mkv(0,0,0,1,6, 0,4,2,0,2,2);
    tbl[9]  = mkv(0,0,0,1,0, 0,4,2,1,0,2);   // boundary miss
    tbl[10] = mkv(1,0,0,1,1, 0,4,2,2,0,2);   // wrong colour
    tbl[11] = mkv(0,0,0,0,6, 0,4,2,2,0,2);
    tbl[12] = mkv(0,0,0,0,0, 0,4,2,2,0,2);   // boundary, bad press consumed note
    tbl[13] = mkv(0,0,1,0,3, 0,4,2,2,0,2);
    tbl[14] = mkv(0,0,1,0,6, 0,4,2,2,0,2);
    tbl[15] = mkv(1,0,1,0,0, 1,5,3,2,1,2);   // good press in boundary cycle
    tbl[16] = mkv(1,1,1,0,1, 0,5,3,3,0,2);   // both buttons with red note
    tbl[17] = mkv(0,0,0,0,2, 0,5,3,3,0,2);
    cd_exp = '{3, 3, 3, 2, 2, 2, 1, 1, 1};

    rst = 1; song_sw = 0; offset = 0; clear_pulses();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 0;
    chk("reset_outputs", dut_vec(), 64'd0);

    // start sequence with countdown thirds
    song_sw = 1; step();
    chk("armed", 64'(t_state), 64'd1);
    btn_start = 1; step(); btn_start = 0;
    chk("cd_enter", {59'd0, t_state, t_countdown}, {59'd0, 3'd2, 2'd3});
    for (int k = 1; k < CD; k++) begin
      step();
      chk("cd_value", 64'(t_countdown), 64'(cd_exp[k]));
    end
    step();
    chk("play_enter", {57'd0, t_state, t_song, t_countdown}, {57'd0, 3'd3, 2'd1, 2'd0});

    // table-driven judging
    for (int i = 0; i < 18; i++) begin
      btn_red = tbl[i].red; btn_blue = tbl[i].blue;
      note_r = tbl[i].nr; note_b = tbl[i].nb; offset = tbl[i].off;
      step();
      chk("tbl_delete", 64'(t_delete), 64'(tbl[i].del));
      chk("tbl_stats", {12'd0, t_score, t_hit, t_miss, t_combo, t_max},
          {12'd0, tbl[i].score, tbl[i].hit, tbl[i].miss, tbl[i].combo, tbl[i].maxc});
    end
    clear_pulses(); offset = 0;

    // end of song and yellow button
    finish = 1; step(); finish = 0;
    chk("result_enter", {59'd0, t_state, t_song}, {59'd0, 3'd4, 2'd0});
    btn_start = 1; step(); btn_start = 0;
    chk("yellow_on", {60'd0, t_state, t_yellow}, {60'd0, 3'd0, 1'b1});
    step();
    chk("yellow_off", 64'(t_yellow), 64'd0);

    // combo bonus: 12 perfect hits, stats cleared on start
    go_play(2);
    chk("stats_cleared", {12'd0, t_score, t_hit, t_miss, t_combo, t_max}, 64'd0);
    chk("song2", 64'(t_song), 64'd2);
    repeat (12) perfect_hit();
    chk("combo12_score", 64'(t_score), 64'd38);
    chk("combo12_max", 64'(t_max), 64'd12);

    // finish coincident with a good press
    offset = 4; note_r = 1; btn_red = 1; finish = 1; step(); clear_pulses(); offset = 0;
    chk("finish_press", {34'd0, t_state, t_delete, t_score, t_hit},
        {34'd0, 3'd4, 1'b1, 16'd42, 10'd13});
    btn_start = 1; step(); btn_start = 0;

    // saturation of score, hit count and combo
    go_play(3);
    repeat (16400) perfect_hit();
    chk("sat_score", 64'(t_score), 64'hFFFF);
    chk("sat_counts", {38'd0, t_hit, t_combo, t_max}, {38'd0, 10'd1023, 8'd255, 8'd255});
    finish = 1; step(); finish = 0;
    btn_start = 1; step(); btn_start = 0;

    // random stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) song_sw = 2'($urandom_range(0, 3));
      btn_start = ($urandom_range(0, 7) == 0);
      finish    = ($urandom_range(0, 63) == 0);
      btn_red   = ($urandom_range(0, 3) == 0);
      btn_blue  = ($urandom_range(0, 3) == 0);
      note_r    = ($urandom_range(0, 2) == 0);
      note_b    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) offset = 3'($urandom_range(0, 6));
      else offset = (offset == 3'd6) ? 3'd0 : offset + 3'd1;
      step();
    end
    clear_pulses(); offset = 0;

    // asynchronous reset in the middle of PLAY
    @(posedge clk); #3 rst = 1; #3 rst = 0; model_reset();
    go_play(2);
    perfect_hit();
    chk("pre_reset_song", 64'(t_song), 64'd2);
    @(posedge clk); #3 rst = 1; #1;
    chk("rst_midplay", dut_vec(), 64'd0);
    #2 rst = 0; model_reset();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rhythm_game_ctrl.md
# rhythm_game_ctrl

Session controller for the LED-matrix rhythm game. It sequences song selection, countdown, play and result phases, and drives the note shifter's `song`, `delete` and `yellow_button` inputs. It judges red/blue player presses against the shifter's judge-row outputs and keeps score, hit/miss counts and combo statistics for the display logic.

## Interface
- `COUNTDOWN_CYC`, default 30_000_000 — cycles spent in COUNTDOWN (width 25).
- `PERF_LO`, default 3 — lowest `offset` value judged PERFECT.
- `PERF_HI`, default 5 — highest `offset` value judged PERFECT.
- `COMBO_BONUS`, default 10 — combo count at or above which a hit earns +1 point.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_red`, `btn_blue` in 1 each: debounced single-cycle press pulses.
- `btn_start` in 1: debounced single-cycle yellow-button pulse.
- `song_sw` in 2: song select switches; 0 means none.
- `note_R_judge`, `note_B_judge` in 1 each: shifter judge-row note present (red/blue).
- `offset` in 3: shifter pixel phase, 0..6.
- `finish` in 1: shifter end-of-song indication.
- `song` out 2: song selection to the shifter.
- `delete` out 1: single-cycle pulse that clears the judged note.
- `yellow_button` out 1: single-cycle pulse that releases the shifter from FINISH.
- `state` out 3: current FSM state.
- `countdown` out 2: 3/2/1 during COUNTDOWN, 0 otherwise.
- `score` out 16: saturating score.
- `hit_cnt`, `miss_cnt` out 10 each: saturating counters.
- `combo`, `max_combo` out 8 each: saturating combo and best combo.

## Operation
- **States:** IDLE=0, ARMED=1, COUNTDOWN=2, PLAY=3, RESULT=4.
- **IDLE:**
  - go to ARMED when `song_sw`≠0.
  - `song`=0.
- **ARMED:**
  - go back to IDLE if `song_sw`=0.
  - on `btn_start`, latch `song_sw` into `song_lat` and go to COUNTDOWN.
  - clear `score`, `hit_cnt`, `miss_cnt`, `combo` and `max_combo` on that same edge.
- **COUNTDOWN:**
  - a counter runs 0..`COUNTDOWN_CYC`-1, then the FSM goes to PLAY.
  - `countdown` = 3 for the first third, 2 for the second, 1 for the last; thirds are computed from precomputed thresholds, with no divider.
- **PLAY:**
  - `song`=`song_lat`.
  - go to RESULT when `finish`=1.
  - `btn_start` and `song_sw` changes are ignored.
- **RESULT:**
  - `song`=0; statistics hold.
  - on `btn_start`, go to IDLE and pulse `yellow_button` for 1 cycle.
- **Judging:** PLAY only; evaluated every cycle.
  - A *good press* is `btn_red` alone with `note_R_judge`=1, or `btn_blue` alone with `note_B_judge`=1, with `hit_flag`=0.
  - On a good press:
    - pulse `delete`; set `hit_flag`.
    - increment `hit_cnt` and `combo`.
    - update `max_combo` = max(`max_combo`, new `combo`).
    - add points: 3 if `PERF_LO`≤`offset`≤`PERF_HI`, else 1; +1 if the pre-increment `combo`≥`COMBO_BONUS`.
  - A *bad press* is a wrong colour while a note is present, or `btn_red` and `btn_blue` in the same cycle while any note is present.
    - On a bad press: increment `miss_cnt`, clear `combo`, set `hit_flag`. The note is consumed; there is no `delete`.
  - A press with no note present is ignored.
- **Slot tracking:**
  - `note_seen` is set whenever either judge input is 1.
  - A slot boundary is `offset_d`=6 and `offset`=0.
  - At a boundary, if `note_seen`=1 and `hit_flag`=0: increment `miss_cnt` and clear `combo`.
  - Then clear both flags.
  - A press in the boundary cycle is judged first; its `hit_flag` update suppresses the miss.
- **Arithmetic:**
  - `score` saturates at 16'hFFFF.
  - `hit_cnt`/`miss_cnt` saturate at 1023.
  - `combo`/`max_combo` saturate at 255.

## Timing
- **Reset values:** all outputs 0; `state`=IDLE; internal counters, flags and `offset_d` are 0.
- **Latency:**
  - `delete`, counter and score updates are registered, visible 1 cycle after the press cycle.
  - `song` is registered; it becomes `song_lat` on the first PLAY cycle and 0 on the first RESULT cycle.
- **Countdown:** COUNTDOWN lasts exactly `COUNTDOWN_CYC` cycles.
- **`yellow_button`:** asserted exactly 1 cycle, coincident with the RESULT→IDLE transition.
- **`finish` during a press:** the transition to RESULT wins; a press in that cycle is still judged.
- **Reset mid-operation:** an asynchronous return to IDLE; `song` drops to 0 immediately.

## Structure
- **Shared package `rhythm_pkg`:**
  - state encoding.
  - point constants: PERFECT=3, GOOD=1, BONUS=1.
  - saturation limits.
  - `OFFSET_MAX`=6.
- **Sub-module `note_judge`:**
  - inputs: buttons, judge inputs, `offset`, `hit_flag`.
  - outputs: `good`, `bad`, `perfect`, `boundary`.
- The FSM, statistics registers and slot flags stay in `rhythm_game_ctrl`.

## Test plan
- **Start sequence:** `song_sw`=1, `btn_start` pulse → COUNTDOWN for `COUNTDOWN_CYC` cycles, `countdown` 3→2→1, then PLAY with `song`=1.
- **Perfect vs good:**
  - `note_R_judge`=1, `btn_red` at `offset`=4 → `delete` pulse, `score`=3, `hit_cnt`=1, `combo`=1.
  - the same at `offset`=1 → +1 point.
- **Miss paths:**
  - `note_B_judge` held through an `offset` 6→0 boundary with no press → `miss_cnt`=1, `combo`=0.
  - wrong-colour press → `miss_cnt`+1 and no `delete`.
- **Combo bonus and saturation:**
  - 12 consecutive perfect hits → `score`=3·10+4·2=38, `max_combo`=12.
  - preload near 16'hFFFF → `score` holds at 16'hFFFF.
- **Simultaneous events:**
  - a good press in the boundary cycle → hit counted, no miss.
  - `btn_red`+`btn_blue` together with a red note → `miss_cnt`+1.
- **End and reset:**
  - `finish`=1 → RESULT, `song`=0; `btn_start` → 1-cycle `yellow_button`, IDLE.
  - `rst` mid-PLAY → all outputs 0.
